fibonacci_gen: RTL and testbench
================================

Name: fibonacci_gen

Overview:
Free-running Fibonacci sequence generator. It emits one term per enabled clock on a registered output bus, starting at F(0)=0. When the next term would not fit in the output width, the sequence restarts at 0. It is a standalone leaf block, driven by a clock, an asynchronous active-low reset and a count enable.

Parameters:
WIDTH, 12, output width in bits; the largest term emitted is the largest Fibonacci number ≤ 2^WIDTH-1 (2584 for WIDTH=12).

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-low (0 = in reset)
enb  input  1  count enable; 1 = advance one term on this rising edge
fibout  output  WIDTH  current Fibonacci term, registered

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-low.
- Internal state:
  - cur: WIDTH bits, equals fibout.
  - nxt: WIDTH+1 bits, the following term; the extra MSB flags overflow.
- Reset (rst=0, asserted at any time, no clock needed):
  - cur=0, nxt=1, so fibout=0 immediately.
  - State is held while rst=0, regardless of clk or enb.
- Release of rst is sampled at the next clk edge. The first enabled edge after release gives fibout=1.
- Rising clk with rst=1 and enb=0: all state holds; fibout unchanged.
- Rising clk with rst=1, enb=1, nxt[WIDTH]=0 (normal step):
  - cur <= nxt[WIDTH-1:0]
  - nxt <= zero-extended cur + nxt, computed at WIDTH+1 bits.
- Rising clk with rst=1, enb=1, nxt[WIDTH]=1 (wrap step):
  - cur <= 0, nxt <= 1.
  - The sequence restarts exactly as after reset.
- Latency: fibout changes on the same rising edge that samples enb=1. It has zero wait states and no handshake.
- Sequence for WIDTH=12: 0,1,1,2,3,5,8,13,21,34,55,89,144,233,377,610,987,1597,2584, then 0,1,1,...
  - Period: 19 enabled cycles.
  - 2584 is never followed by 4181 or by a truncated value (4181 mod 4096 = 85 must never appear).
- enb may toggle every cycle. Disabled cycles are fully transparent and do not count toward the period.
- fibout comes straight from a flop: no combinational path from enb or rst timing other than the async clear.
- Output is always a valid Fibonacci number. X/undefined values must never appear after the first reset assertion.

Decomposition:
- Shared package fibonacci_pkg:
  - FIB_WIDTH_DEFAULT = 12
  - FIB_RST_CUR = 0
  - FIB_RST_NXT = 1
- Optional single sub-module fib_step (combinational):
  - Inputs: cur, nxt.
  - Outputs: next_cur, next_nxt, wrap flag.
  - Holds the add and wrap mux.
- The top level holds the registers, the enable gating and the async reset.

Test Plan:
- Hold rst=0 for 3 clocks with enb=1 -> fibout=0 every cycle; on release the first enabled edge -> fibout=1.
- rst=1, enb=1 for 10 edges -> fibout sequence 1,1,2,3,5,8,13,21,34,55 (binary 000000110111 at the end).
- Mid-sequence at fibout=21, drive enb=0 for 5 edges -> fibout stays 21; enb=1 again -> 34, 55.
- 18 consecutive enabled edges from reset -> fibout=2584 (101000011000); 19th edge -> 0; 20th -> 1; 21st -> 1 (wrap; 85 never seen).
- At fibout=144, assert rst=0 between clock edges -> fibout=0 immediately without a clock edge; after release the sequence restarts 1,1,2.
- WIDTH=4 build, enb=1 from reset -> 0,1,1,2,3,5,8,13,0,1 (wrap after 13 because 21>15).

Source files
------------

// File: rtl/fibonacci_pkg.sv
// Shared constants for the Fibonacci sequence generator.
// The reset pair (cur, nxt) = (0, 1) also serves as the wrap target.
package fibonacci_pkg;

  localparam int FIB_WIDTH_DEFAULT = 12;
  localparam int FIB_RST_CUR       = 0;
  localparam int FIB_RST_NXT       = 1;

endpackage : fibonacci_pkg

// File: rtl/fib_step.sv
// Combinational step of the Fibonacci generator.
// Adds the current pair, or restarts at (0, 1) once the following term has overflowed.
module fib_step
  import fibonacci_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH:0]   nxt,
  output logic [WIDTH-1:0] next_cur,
  output logic [WIDTH:0]   next_nxt,
  output logic             wrap
);

  localparam int NW = WIDTH + 1;

  // The extra MSB of nxt marks a term that no longer fits on the output bus.
  assign wrap = nxt[WIDTH];

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_cur = nxt[WIDTH-1:0];
    next_nxt = {1'b0, cur} + nxt;
    if (wrap) begin
      next_cur = WIDTH'(FIB_RST_CUR);
      next_nxt = NW'(FIB_RST_NXT);
    end
  end

endmodule : fib_step

// File: rtl/fibonacci_gen.sv
// Free-running Fibonacci generator: one term per enabled clock, restarting at 0
// when the next term would not fit in WIDTH bits.
module fibonacci_gen
  import fibonacci_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  output logic [WIDTH-1:0] fibout
);

  localparam int NW = WIDTH + 1;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] next_cur;
  logic [WIDTH:0]   nxt;
  logic [WIDTH:0]   next_nxt;
  logic             wrap;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .cur      (cur),
    .nxt      (nxt),
    .next_cur (next_cur),
    .next_nxt (next_nxt),
    .wrap     (wrap)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of cur and nxt, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= WIDTH'(FIB_RST_CUR);
      nxt <= NW'(FIB_RST_NXT);
    end else if (enb) begin
      cur <= next_cur;
      nxt <= next_nxt;
    end
  end

  assign fibout = cur;

  // An enabled step taken while the following term has overflowed must restart at 0.
  a_wrap_to_zero : assert property (
    @(posedge clk) disable iff (!rst) (enb && wrap) |=> (fibout == '0)
  );

endmodule : fibonacci_gen

// File: tb/tb_fibonacci_gen.sv
// Directed bench for fibonacci_gen: reset, stepping, enable hold, wrap,
// asynchronous reset mid-sequence, and a WIDTH=4 instance.
module tb_fibonacci_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [11:0] fibout;
  logic        rst4;
  logic        enb4;
  logic [3:0]  fibout4;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;

  // Hand-computed terms, one period each.
  int seq12 [19] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377,
                     610, 987, 1597, 2584};
  int seq4 [8]   = '{0, 1, 1, 2, 3, 5, 8, 13};

  fibonacci_gen dut (
    .clk    (clk),
    .rst    (rst),
    .enb    (enb),
    .fibout (fibout)
  );

  fibonacci_gen #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst4),
    .enb    (enb4),
    .fibout (fibout4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one rising edge; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run n enabled edges on the 12-bit instance, checking each term.
  task automatic run12(input int n, input string tag);
    enb = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      k++;
      check($sformatf("%s[%0d]", tag, k), 32'(fibout), 32'(seq12[k % 19]));
      if (fibout == 12'd85) check("no_truncated_85", 32'(fibout), 32'd0);
    end
  endtask

  initial begin
    rst  = 1'b0;
    enb  = 1'b1;
    rst4 = 1'b0;
    enb4 = 1'b0;

    // Reset held with enb=1: output pinned at 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", 32'(fibout), 32'd0);
    end

    // Release, then 8 edges up to 21.
    rst = 1'b1;
    k   = 0;
    run12(8, "seq");
    check("at_21", 32'(fibout), 32'd21);

    // Disabled edges hold the term.
    enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("enb_hold", 32'(fibout), 32'd21);
    end
    run12(2, "resume");
    check("at_55_bin", 32'(fibout), 32'b000000110111);

    // On to 2584 (edge 18), then wrap to 0, 1, 1.
    run12(8, "climb");
    check("max_term", 32'(fibout), 32'b101000011000);
    run12(3, "wrap");
    check("after_wrap", 32'(fibout), 32'd1);

    // enb toggling every cycle: only enabled edges advance.
    for (int i = 0; i < 4; i++) begin
      enb = i[0] ? 1'b0 : 1'b1;
      tick();
      if (enb) k++;
      check($sformatf("toggle[%0d]", i), 32'(fibout), 32'(seq12[k % 19]));
    end

    // Fresh reset, climb to 144, then assert reset between edges.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    k   = 0;
    run12(12, "to144");
    check("at_144", 32'(fibout), 32'd144);
    #2;
    rst = 1'b0;
    #1;
    check("async_clear", 32'(fibout), 32'd0);
    @(negedge clk);
    check("async_hold", 32'(fibout), 32'd0);
    rst = 1'b1;
    k   = 0;
    run12(3, "restart");

    // WIDTH=4 instance: wraps after 13 since 21 exceeds 15.
    rst4 = 1'b1;
    enb4 = 1'b1;
    check("w4[0]", 32'(fibout4), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("w4[%0d]", i), 32'(fibout4), 32'(seq4[i % 8]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fibonacci_gen
